// File: rtl/conv_acc_pkg.sv
// Shared constants, FSM state type and a lane sign-extension helper for the
// convolution accumulator readout path (acc_drain and its saturator).
package conv_acc_pkg;

    localparam int ACC_W  = 48;   // accumulator word width
    localparam int LANE_W = 24;   // lane width when the adder runs split
    localparam int OUT_W  = 16;   // output sample width
    localparam int SH_W   = 5;    // per-word right-shift count width

    localparam logic [OUT_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [OUT_W-1:0] SAT_MIN = 16'h8000;

    // state  | meaning
    // IDLE   | ready for a new accumulator word
    // SHIFT  | arithmetic right shift, one bit per cycle, counter running down
    // EMIT0  | lane 0 sample being loaded / offered downstream
    // EMIT1  | lane 1 sample offered downstream (split words only)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EMIT0 = 2'd2,
        EMIT1 = 2'd3
    } drain_state_t;

    function automatic logic [ACC_W-1:0] sext_lane(input logic [LANE_W-1:0] v);
        return {{(ACC_W-LANE_W){v[LANE_W-1]}}, v};
    endfunction

endpackage

// File: rtl/acc_lane_sat.sv
// Combinational saturator: signed 48-bit lane value down to signed 16 bits.
// Ports:
//   lane_i      signed lane value (already shifted)
//   force_i     adder overflow forcing: ignore lane_i and clip to a rail
//   force_pos_i rail selection when forcing (1 = +max, 0 = -min)
//   data_o      saturated 16-bit sample
//   sat_o       1 when the sample was clipped or forced
module acc_lane_sat
    import conv_acc_pkg::*;
(
    input  logic signed [ACC_W-1:0] lane_i,
    input  logic                    force_i,
    input  logic                    force_pos_i,
    output logic [OUT_W-1:0]        data_o,
    output logic                    sat_o
);

    localparam logic signed [ACC_W-1:0] MAX_EXT = {{(ACC_W-OUT_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] MIN_EXT = {{(ACC_W-OUT_W){1'b1}}, SAT_MIN};

    always_comb begin
        data_o = lane_i[OUT_W-1:0];
        sat_o  = 1'b0;
        if (force_i) begin
            // Overflowed sum: bit 47 has the wrong sign, so the true value
            // lies beyond the rail opposite to what the stored bits suggest.
            data_o = force_pos_i ? SAT_MAX : SAT_MIN;
            sat_o  = 1'b1;
        end else if (lane_i > MAX_EXT) begin
            data_o = SAT_MAX;
            sat_o  = 1'b1;
        end else if (lane_i < MIN_EXT) begin
            data_o = SAT_MIN;
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/acc_drain.sv
// Accumulator readout stage. Takes one 48-bit accumulator word (one 48-bit
// lane or two 24-bit lanes), shifts each lane arithmetically right one bit
// per cycle, saturates to signed 16 bits and streams the samples out.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input word handshake (ready only in IDLE)
//   in_data, in_split       accumulator word and lane mode
//   in_ovf                  adder signed-overflow flag for bit 47
//   shift_amt               right-shift count for this word
//   out_valid/out_ready     output sample handshake
//   out_data, out_last      sample and final-lane-of-word marker
//   out_sat                 sample was clipped or forced by overflow
module acc_drain
    import conv_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_data,
    input  logic              in_split,
    input  logic              in_ovf,
    input  logic [SH_W-1:0]   shift_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              out_sat
);

    drain_state_t             state_q, state_d;
    logic signed [ACC_W-1:0]  lane0_q, lane0_d;
    logic signed [ACC_W-1:0]  lane1_q, lane1_d;
    logic [SH_W-1:0]          cnt_q, cnt_d;
    logic                     split_q, split_d;
    logic                     ovf_q, ovf_d;
    logic                     msb_q, msb_d;
    logic                     ovalid_q, ovalid_d;
    logic [OUT_W-1:0]         odata_q, odata_d;
    logic                     olast_q, olast_d;
    logic                     osat_q, osat_d;

    logic                     sel_lane1;
    logic signed [ACC_W-1:0]  sat_lane;
    logic                     sat_force;
    logic [OUT_W-1:0]         sat_data;
    logic                     sat_flag;

    // In EMIT0 with a sample already on the port, the saturator is looking
    // ahead at lane 1 so the lane-0 handshake can load it in the same edge.
    assign sel_lane1 = (state_q == EMIT0) && ovalid_q;
    assign sat_lane  = sel_lane1 ? lane1_q : lane0_q;
    // Overflow only corrupts the lane that holds bit 47.
    assign sat_force = ovf_q && (!split_q || sel_lane1);

    acc_lane_sat u_sat (
        .lane_i      (sat_lane),
        .force_i     (sat_force),
        .force_pos_i (msb_q),
        .data_o      (sat_data),
        .sat_o       (sat_flag)
    );

    always_comb begin
        state_d  = state_q;
        lane0_d  = lane0_q;
        lane1_d  = lane1_q;
        cnt_d    = cnt_q;
        split_d  = split_q;
        ovf_d    = ovf_q;
        msb_d    = msb_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        osat_d   = osat_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    split_d = in_split;
                    ovf_d   = in_ovf;
                    msb_d   = in_data[ACC_W-1];
                    cnt_d   = shift_amt;
                    if (in_split) begin
                        lane0_d = sext_lane(in_data[LANE_W-1:0]);
                        lane1_d = sext_lane(in_data[ACC_W-1:LANE_W]);
                    end else begin
                        lane0_d = in_data;
                        lane1_d = '0;
                    end
                    state_d = (shift_amt != '0) ? SHIFT : EMIT0;
                end
            end

            SHIFT: begin
                lane0_d = lane0_q >>> 1;
                lane1_d = lane1_q >>> 1;
                cnt_d   = cnt_q - SH_W'(1);
                if (cnt_q == SH_W'(1)) begin
                    state_d = EMIT0;
                end
            end

            EMIT0: begin
                if (!ovalid_q) begin
                    ovalid_d = 1'b1;
                    odata_d  = sat_data;
                    olast_d  = !split_q;
                    osat_d   = sat_flag;
                end else if (out_ready) begin
                    if (split_q) begin
                        odata_d = sat_data;
                        olast_d = 1'b1;
                        osat_d  = sat_flag;
                        state_d = EMIT1;
                    end else begin
                        ovalid_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end

            EMIT1: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lane0_q  <= '0;
            lane1_q  <= '0;
            cnt_q    <= '0;
            split_q  <= 1'b0;
            ovf_q    <= 1'b0;
            msb_q    <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            osat_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane0_q  <= lane0_d;
            lane1_q  <= lane1_d;
            cnt_q    <= cnt_d;
            split_q  <= split_d;
            ovf_q    <= ovf_d;
            msb_q    <= msb_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            osat_q   <= osat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ovalid_q;
    assign out_data  = odata_q;
    assign out_last  = olast_q;
    assign out_sat   = osat_q;

endmodule
